spad_arbiter: RTL

SPAD_ARBITER -- requirements
Module: spad_arbiter

---
 rtl/spad_pkg.sv | 12 +
 rtl/spad_bank.sv | 31 +++
 rtl/spad_rr_arb.sv | 34 +++
 rtl/spad_arbiter.sv | 99 +++++++++
 4 files changed

// File: rtl/spad_pkg.sv
// Shared constants for the scratchpad arbiter slice: default bus widths,
// counter width and requester indices.
package spad_pkg;

  localparam int unsigned DATAWIDTH_DEF = 32;
  localparam int unsigned ADDRWIDTH_DEF = 18;
  localparam int unsigned CNTWIDTH      = 16;

  localparam logic REQ_0 = 1'b0;
  localparam logic REQ_1 = 1'b1;

endpackage

// File: rtl/spad_bank.sv
// Single-port synchronous SRAM bank with active-low enables; read data
// appears on Q the cycle after the read is issued and holds until the next read.
module spad_bank
  import spad_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DATAWIDTH_DEF,
  parameter int unsigned ADDRWIDTH = ADDRWIDTH_DEF
) (
  input  logic                 CLK,
  input  logic                 CEN,
  input  logic                 WEN,
  input  logic [ADDRWIDTH-1:0] A,
  input  logic [DATAWIDTH-1:0] D,
  output logic [DATAWIDTH-1:0] Q
);

  localparam int unsigned DEPTH = 1 << ADDRWIDTH;

  logic [DATAWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!WEN) begin
        mem[A] <= D;
      end else begin
        Q <= mem[A];
      end
    end
  end

endmodule

// File: rtl/spad_rr_arb.sv
// Two-way round-robin grant selection. The pointer only moves on contested
// cycles, so a lone requester never steals the other side's turn.
module spad_rr_arb
  import spad_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic valid_0,
  input  logic valid_1,
  output logic grant_0_c,
  output logic grant_1_c
);

  logic rr_ptr;

  // Grant logic: an uncontested request wins, a contested one goes to rr_ptr
  always_comb begin
    grant_0_c = 1'b0;
    grant_1_c = 1'b0;
    if (!RST) begin
      grant_0_c = valid_0 && (!valid_1 || (rr_ptr == REQ_0));
      grant_1_c = valid_1 && (!valid_0 || (rr_ptr == REQ_1));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr <= REQ_0;
    end else if (valid_0 && valid_1) begin
      rr_ptr <= grant_0_c ? REQ_1 : REQ_0;
    end
  end

endmodule

// File: rtl/spad_arbiter.sv
// Two-requester front end for a single-port scratchpad bank: round-robin
// grant, bank command muxing, one-cycle read response routing, conflict counter.
module spad_arbiter
  import spad_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DATAWIDTH_DEF,
  parameter int unsigned ADDRWIDTH = ADDRWIDTH_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req_valid_0,
  input  logic                 req_valid_1,
  output logic                 req_ready_0,
  output logic                 req_ready_1,
  input  logic                 req_we_0,
  input  logic                 req_we_1,
  input  logic [ADDRWIDTH-1:0] req_addr_0,
  input  logic [ADDRWIDTH-1:0] req_addr_1,
  input  logic [DATAWIDTH-1:0] req_wdata_0,
  input  logic [DATAWIDTH-1:0] req_wdata_1,
  output logic                 rsp_valid_0,
  output logic                 rsp_valid_1,
  output logic [DATAWIDTH-1:0] rsp_rdata_0,
  output logic [DATAWIDTH-1:0] rsp_rdata_1,
  output logic                 CEN,
  output logic                 WEN,
  output logic [ADDRWIDTH-1:0] A,
  output logic [DATAWIDTH-1:0] D,
  input  logic [DATAWIDTH-1:0] Q,
  output logic [CNTWIDTH-1:0]  conflict_cnt
);

  logic                 grant_0;
  logic                 grant_1;
  logic [ADDRWIDTH-1:0] addr_q;
  logic [DATAWIDTH-1:0] data_q;
  logic                 pend_0;
  logic                 pend_1;
  logic [CNTWIDTH-1:0]  cnt_q;

  spad_rr_arb u_rr (
    .CLK       (CLK),
    .RST       (RST),
    .valid_0   (req_valid_0),
    .valid_1   (req_valid_1),
    .grant_0_c (grant_0),
    .grant_1_c (grant_1)
  );

  assign req_ready_0 = grant_0;
  assign req_ready_1 = grant_1;

  // Bank command: idle cycles keep A/D parked on the last granted values
  always_comb begin
    CEN = 1'b1;
    WEN = 1'b1;
    A   = addr_q;
    D   = data_q;
    if (grant_1) begin
      CEN = 1'b0;
      WEN = ~req_we_1;
      A   = req_addr_1;
      D   = req_wdata_1;
    end else if (grant_0) begin
      CEN = 1'b0;
      WEN = ~req_we_0;
      A   = req_addr_0;
      D   = req_wdata_0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q <= '0;
      data_q <= '0;
      pend_0 <= 1'b0;
      pend_1 <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (grant_0 || grant_1) begin
        addr_q <= A;
        data_q <= D;
      end
      pend_0 <= grant_0 && !req_we_0;
      pend_1 <= grant_1 && !req_we_1;
      if (req_valid_0 && req_valid_1 && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNTWIDTH'(1);
      end
    end
  end

  // A read in flight when reset hits is dropped by masking with RST
  assign rsp_valid_0  = pend_0 && !RST;
  assign rsp_valid_1  = pend_1 && !RST;
  assign rsp_rdata_0  = Q;
  assign rsp_rdata_1  = Q;
  assign conflict_cnt = cnt_q;

endmodule
